// File: rtl/conv_channel_mac_engine.sv
// Multi-channel convolution MAC engine.
// Takes one K*K window plus kernel per channel per beat and walks the taps one per cycle,
// accumulating in every lane in parallel. Beats can be chained (acc_first/acc_last) for depth
// tiling. The result is either one value per lane or a single cross-lane sum in lane 0.
module conv_channel_mac_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 4,
  parameter int SIGNED      = 1,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNELS) + 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_in,
  input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel_in,
  input  logic                                              acc_first,
  input  logic                                              acc_last,
  input  logic                                              mode_sum,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [CHANNELS*ACC_WIDTH-1:0]                     out_data,
  output logic                                              busy
);

  localparam int TAPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int BEAT_W  = CHANNELS * TAPS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MAC     = 2'd1,
    ST_COMBINE = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [BEAT_W-1:0]        win_r;
  logic [BEAT_W-1:0]        ker_r;
  logic                     last_r;
  logic                     mode_r;
  logic [ACC_WIDTH-1:0]     acc_r [CHANNELS];
  logic [ACC_WIDTH-1:0]     prod_ext_s [CHANNELS];
  logic [ACC_WIDTH-1:0]     sum_s;
  logic [CHANNELS*ACC_WIDTH-1:0] comb_data_s;
  logic [CHANNELS*ACC_WIDTH-1:0] out_data_r;
  logic                     out_valid_r;
  logic                     in_ready_r;
  logic                     busy_r;
  logic                     accept_s;
  logic                     tap_done_s;

  assign accept_s   = in_valid & in_ready_r;
  assign tap_done_s = (cnt_r == LAST_TAP);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Per-lane product of the current tap, extended to accumulator width.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] win_tap_s;
    logic [DATA_WIDTH-1:0] ker_tap_s;
    logic [PROD_W-1:0]     prod_s;

    assign win_tap_s = win_r[(c*TAPS + int'(cnt_r))*DATA_WIDTH +: DATA_WIDTH];
    assign ker_tap_s = ker_r[(c*TAPS + int'(cnt_r))*DATA_WIDTH +: DATA_WIDTH];

    if (SIGNED != 0) begin : g_signed
      // Sign-extending both operands first makes the modular product equal the signed product.
      assign prod_s = {{DATA_WIDTH{win_tap_s[DATA_WIDTH-1]}}, win_tap_s}
                    * {{DATA_WIDTH{ker_tap_s[DATA_WIDTH-1]}}, ker_tap_s};
      assign prod_ext_s[c] = {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end else begin : g_unsigned
      assign prod_s = {{DATA_WIDTH{1'b0}}, win_tap_s} * {{DATA_WIDTH{1'b0}}, ker_tap_s};
      assign prod_ext_s[c] = {{(ACC_WIDTH-PROD_W){1'b0}}, prod_s};
    end
  end

  // Cross-lane sum of the accumulators (wraps at ACC_WIDTH).
  always_comb begin
    sum_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s = sum_s + acc_r[c];
    end
  end

  // Result image: per-lane accumulators, or the total in lane 0 with other lanes zero.
  always_comb begin
    comb_data_s = '0;
    if (mode_r) begin
      comb_data_s[0 +: ACC_WIDTH] = sum_s;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        comb_data_s[c*ACC_WIDTH +: ACC_WIDTH] = acc_r[c];
      end
    end
  end

  // Next-state logic for the IDLE -> MAC -> COMBINE -> OUT sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_MAC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (tap_done_s) begin
          state_nxt_s = last_r ? ST_COMBINE : ST_IDLE;
        end else begin
          state_nxt_s = ST_MAC;
        end
      end
      ST_COMBINE: begin
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, operand capture, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      win_r       <= '0;
      ker_r       <= '0;
      last_r      <= 1'b0;
      mode_r      <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_r[c] <= '0;
      end
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r     <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            win_r  <= window_in;
            ker_r  <= kernel_in;
            last_r <= acc_last;
            cnt_r  <= '0;
            // Mode is a per-tile property: only the opening beat of a tile may change it.
            if (acc_first) begin
              mode_r <= mode_sum;
              for (int c = 0; c < CHANNELS; c++) begin
                acc_r[c] <= '0;
              end
            end else begin
              mode_r <= mode_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_MAC: begin
          for (int c = 0; c < CHANNELS; c++) begin
            acc_r[c] <= acc_r[c] + prod_ext_s[c];
          end
          if (tap_done_s) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_COMBINE: begin
          out_data_r  <= comb_data_s;
          out_valid_r <= 1'b1;
        end
        ST_OUT: begin
          // Result is held until taken; taking it also closes the tile.
          if (out_ready) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
              acc_r[c] <= '0;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_channel_mac_engine.sv
// Directed self-checking bench for conv_channel_mac_engine (K=3, C=2).
// A signed and an unsigned instance share all inputs.
module tb_conv_channel_mac_engine;

  localparam int DW     = 32;
  localparam int K      = 3;
  localparam int C      = 2;
  localparam int TAPS   = K * K;
  localparam int ACC_W  = 2*DW + $clog2(TAPS*C) + 4;
  localparam int BEAT_W = C * TAPS * DW;
  localparam int OUT_W  = C * ACC_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [BEAT_W-1:0] window_in;
  logic [BEAT_W-1:0] kernel_in;
  logic              acc_first;
  logic              acc_last;
  logic              mode_sum;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic              in_ready_u;
  logic              out_valid_u;
  logic [OUT_W-1:0]  out_data_u;
  logic              busy_u;

  int n_checks;
  int n_fail;
  int cyc;
  logic [OUT_W-1:0] held_s;

  conv_channel_mac_engine #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .CHANNELS(C), .SIGNED(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .window_in(window_in), .kernel_in(kernel_in), .acc_first(acc_first),
    .acc_last(acc_last), .mode_sum(mode_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  conv_channel_mac_engine #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .CHANNELS(C), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .window_in(window_in), .kernel_in(kernel_in), .acc_first(acc_first),
    .acc_last(acc_last), .mode_sum(mode_sum), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_data(out_data_u), .busy(busy_u)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] pack2(input logic [ACC_W-1:0] l0, input logic [ACC_W-1:0] l1);
    return {l1, l0};
  endfunction

  task automatic set_ops(input logic [DW-1:0] w, input logic [DW-1:0] k);
    for (int i = 0; i < C*TAPS; i++) begin
      window_in[i*DW +: DW] = w;
      kernel_in[i*DW +: DW] = k;
    end
  endtask

  // Present one beat at a negedge; returns at the next negedge with inputs released.
  task automatic drive_beat(input string tag, input logic first, input logic last, input logic mode);
    check({tag, "_rdy"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    acc_first = first;
    acc_last  = last;
    mode_sum  = mode;
    @(negedge clk);
    in_valid  = 1'b0;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    mode_sum  = 1'b0;
  endtask

  // Count cycles (accept cycle = 0) until out_valid, bounded.
  task automatic wait_out(input string tag, output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_lat"}, n, 11);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovld0"}, out_valid, 1'b0);
    check({tag, "_odat0"}, out_data, '0);
    check({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  // Directed sequence.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    mode_sum  = 1'b0;
    out_ready = 1'b0;
    window_in = '0;
    kernel_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);

    // Single shot, per-channel: 9 * (1*2) = 18 per lane.
    set_ops(32'd1, 32'd2);
    drive_beat("pc", 1'b1, 1'b1, 1'b0);
    check("pc_busy", busy, 1'b1);
    check("pc_in_ready_low", in_ready, 1'b0);
    wait_out("pc", cyc);
    check("pc_data", out_data, pack2(ACC_W'(18), ACC_W'(18)));
    release_out("pc");
    check("pc_busy_idle", busy, 1'b0);

    // Same stimulus, cross-channel sum: 36 in lane 0.
    drive_beat("sum", 1'b1, 1'b1, 1'b1);
    wait_out("sum", cyc);
    check("sum_data", out_data, pack2(ACC_W'(36), ACC_W'(0)));
    release_out("sum");

    // Two-beat tile; mode_sum on the second beat must be ignored (acc_first=0).
    set_ops(32'd1, 32'd1);
    drive_beat("tile1", 1'b1, 1'b0, 1'b0);
    cyc = 1;
    while (in_ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("tile_rdy_gap", cyc, 10);
    check("tile_no_out", out_valid, 1'b0);
    drive_beat("tile2", 1'b0, 1'b1, 1'b1);
    wait_out("tile2", cyc);
    check("tile_data", out_data, pack2(ACC_W'(18), ACC_W'(18)));
    release_out("tile2");

    // Signed: -3 * 4 * 9 = -108 per lane.
    set_ops(32'hFFFF_FFFD, 32'd4);
    drive_beat("neg", 1'b1, 1'b1, 1'b0);
    wait_out("neg", cyc);
    check("neg_data", out_data, pack2(ACC_W'(0) - ACC_W'(108), ACC_W'(0) - ACC_W'(108)));
    release_out("neg");

    // 0xFFFFFFFF * 1: unsigned lane = 9*(2^32-1), signed lane = -9.
    set_ops(32'hFFFF_FFFF, 32'd1);
    drive_beat("uns", 1'b1, 1'b1, 1'b0);
    wait_out("uns", cyc);
    check("uns_u_valid", out_valid_u, 1'b1);
    check("uns_u_data", out_data_u, pack2(ACC_W'(64'd38654705655), ACC_W'(64'd38654705655)));
    check("uns_s_data", out_data, pack2(ACC_W'(0) - ACC_W'(9), ACC_W'(0) - ACC_W'(9)));
    release_out("uns");
    check("uns_u_released", out_valid_u, 1'b0);

    // Back-pressure: result held 5 cycles while upstream keeps offering a beat.
    set_ops(32'd3, 32'd5);
    drive_beat("bp", 1'b1, 1'b1, 1'b0);
    wait_out("bp", cyc);
    held_s = pack2(ACC_W'(135), ACC_W'(135));
    set_ops(32'd7, 32'd7);
    in_valid  = 1'b1;
    acc_first = 1'b1;
    acc_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, held_s);
      check("bp_hold_rdy", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    release_out("bp");
    check("bp_not_taken", busy, 1'b0);

    // Reset during tap 4, then a first=0 single shot must start from zero: 9*(2*3)=54.
    set_ops(32'd5, 32'd5);
    drive_beat("rm", 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rm_in_ready", in_ready, 1'b1);
    check("rm_out_valid", out_valid, 1'b0);
    check("rm_busy", busy, 1'b0);
    check("rm_out_data", out_data, '0);
    set_ops(32'd2, 32'd3);
    drive_beat("rm2", 1'b0, 1'b1, 1'b0);
    wait_out("rm2", cyc);
    check("rm2_data", out_data, pack2(ACC_W'(54), ACC_W'(54)));
    release_out("rm2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
